// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the single-cycle MIPS execute slice.
//   - Default datapath widths (data word and word-addressed PC).
//   - Opcode/func field encodings for the supported R-type instructions.
//   - 3-bit ALU operation codes driven by the decoder into mips_alu.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 6;

    // Instruction field encodings
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operation codes (101 is unused and yields zero)
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu.sv
// mips_alu: purely combinational 32-bit (DATA_W) ALU.
// Ports:
//   a, b      in  DATA_W  operands
//   alu_op    in  3       operation code (see mips_pkg ALU_*)
//   result    out DATA_W  operation result
//   zero      out 1       result == 0
//   overflow  out 1       signed overflow, only meaningful for ADD/SUB
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt;

    assign sum  = a + b;
    assign diff = a - b;
    // Signed compare rather than the difference sign bit, so SLT stays
    // correct when the subtraction itself overflows.
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                           (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                           (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: PC incrementer, R-type decoder and ALU of the
// single-cycle MIPS core, plus a registered debug copy of the ALU outputs.
// Ports:
//   clk, rst          clock / asynchronous active-low reset
//   instr             fetched instruction (opcode [31:26], func [5:0])
//   a, b, pc          register-file operands and current word PC
//   pc_next           pc + PC_INC (wraps at 2^PC_W)
//   alu_op, reg_write decoded ALU operation and write enable
//   result, zero, overflow             combinational ALU outputs
//   result_q, zero_q, overflow_q       ALU outputs captured each cycle
//   ovf_sticky        set by any captured overflow, cleared by reset only
module mips_exec_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int PC_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_next,
    output logic [2:0]        alu_op,
    output logic              reg_write,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic [DATA_W-1:0] result_q,
    output logic              zero_q,
    output logic              overflow_q,
    output logic              ovf_sticky
);

    localparam logic [PC_W-1:0] PC_STEP = PC_INC[PC_W-1:0];

    logic [5:0] opcode;
    logic [5:0] func;
    logic       ovf_sticky_q;
    logic       ovf_sticky_d;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign func              = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    // Truncation to PC_W bits gives the modulo wrap.
    assign pc_next = pc + PC_STEP;

    // Unknown opcodes/funcs fall back to ADD with writes suppressed.
    always_comb begin
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        if (opcode == OP_RTYPE) begin
            reg_write = 1'b1;
            case (func)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                default: begin
                    alu_op    = ALU_ADD;
                    reg_write = 1'b0;
                end
            endcase
        end
    end

    mips_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    assign ovf_sticky_d = ovf_sticky_q | overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q     <= '0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            result_q     <= result;
            zero_q       <= zero;
            overflow_q   <= overflow;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
module tb_mips_exec_unit;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic        reg_write;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [5:0]  pc_next;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [5:0]  pc = '0;
    logic [5:0]  pc_next;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;
    logic        ovf_sticky;

    always #5 clk = ~clk;

    mips_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .a          (a),
        .b          (b),
        .pc         (pc),
        .pc_next    (pc_next),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .overflow_q (overflow_q),
        .ovf_sticky (ovf_sticky)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    exp_t reg_q[$];
    logic exp_sticky = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    // Reference model: arithmetic done in 64-bit signed space, overflow is
    // "true sum falls outside the 32-bit signed range".
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] x,
                                   input logic [31:0] y, input logic [5:0] p);
        exp_t   e;
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = sx + sy;
        e.alu_op    = 3'b010;
        e.reg_write = 1'b0;
        e.ovf       = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.result    = r[31:0];
        if (ins[31:26] == 6'd0) begin
            e.reg_write = 1'b1;
            case (ins[5:0])
                6'h20: ;
                6'h22: begin
                    r = sx - sy;
                    e.alu_op = 3'b110;
                    e.ovf    = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                    e.result = r[31:0];
                end
                6'h24: begin e.alu_op = 3'b000; e.ovf = 0; e.result = x & y; end
                6'h25: begin e.alu_op = 3'b001; e.ovf = 0; e.result = x | y; end
                6'h26: begin e.alu_op = 3'b011; e.ovf = 0; e.result = x ^ y; end
                6'h27: begin e.alu_op = 3'b100; e.ovf = 0; e.result = ~(x | y); end
                6'h2A: begin e.alu_op = 3'b111; e.ovf = 0; e.result = (sx < sy) ? 32'd1 : 32'd0; end
                default: e.reg_write = 1'b0;
            endcase
        end
        e.zero    = (e.result == 32'd0);
        e.pc_next = 6'((int'(p) + 1) % 64);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic [31:0] ins, input logic [31:0] x,
                         input logic [31:0] y, input logic [5:0] p);
        exp_t e;
        @(negedge clk);
        instr = ins; a = x; b = y; pc = p;
        exp_q.push_back(model(ins, x, y, p));
        reg_q.push_back(model(ins, x, y, p));
        #1;
        e = exp_q.pop_front();
        check("pc_next",   {26'd0, pc_next},   {26'd0, e.pc_next});
        check("alu_op",    {29'd0, alu_op},    {29'd0, e.alu_op});
        check("reg_write", {31'd0, reg_write}, {31'd0, e.reg_write});
        check("result",    result,             e.result);
        check("zero",      {31'd0, zero},      {31'd0, e.zero});
        check("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
        @(posedge clk);
        #1;
        e = reg_q.pop_front();
        exp_sticky = exp_sticky | e.ovf;
        check("result_q",   result_q,             e.result);
        check("zero_q",     {31'd0, zero_q},      {31'd0, e.zero});
        check("overflow_q", {31'd0, overflow_q},  {31'd0, e.ovf});
        check("ovf_sticky", {31'd0, ovf_sticky},  {31'd0, exp_sticky});
    endtask

    task automatic check_regs_clear(input string tag);
        check({tag, "_result_q"},   result_q,             32'd0);
        check({tag, "_zero_q"},     {31'd0, zero_q},      32'd0);
        check({tag, "_overflow_q"}, {31'd0, overflow_q},  32'd0);
        check({tag, "_ovf_sticky"}, {31'd0, ovf_sticky},  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] fns [0:8];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h21};

        repeat (2) @(posedge clk);
        #1;
        check_regs_clear("reset");
        @(negedge clk);
        rst = 1'b1;

        // Decode and PC wrap
        apply(32'h0022_1820, 32'd1, 32'd2, 6'd5);
        apply(rtype(6'h2A), 32'hFFFF_FFFF, 32'd1, 6'd63);
        apply({6'h23, 26'h0}, 32'd10, 32'd20, 6'd7);
        apply(rtype(6'h00), 32'd3, 32'd4, 6'd0);

        // Add/sub overflow, then clean ops keep the sticky bit
        apply(rtype(6'h20), 32'h7FFF_FFFF, 32'd1, 6'd1);
        apply(rtype(6'h20), 32'hFFFF_FFFF, 32'd1, 6'd2);
        apply(rtype(6'h22), 32'h8000_0000, 32'd1, 6'd3);

        // Logic ops
        apply(rtype(6'h24), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd4);
        apply(rtype(6'h25), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd5);
        apply(rtype(6'h26), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd6);
        apply(rtype(6'h27), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd7);

        // Signed SLT
        apply(rtype(6'h2A), 32'd1, 32'hFFFF_FFFF, 6'd8);
        apply(rtype(6'h2A), 32'h8000_0000, 32'h7FFF_FFFF, 6'd9);

        // Registered zero path
        apply(rtype(6'h22), 32'd5, 32'd5, 6'd10);

        // Asynchronous reset mid-cycle clears the registers immediately
        #2;
        rst = 1'b0;
        exp_sticky = 1'b0;
        #1;
        check_regs_clear("async_rst");
        @(negedge clk);
        rst = 1'b1;

        apply(rtype(6'h22), 32'd9, 32'd4, 6'd11);

        // Random mix including unrecognised funcs and opcodes
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ins;
            ins = rtype(fns[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0) ins[31:26] = 6'($urandom_range(1, 63));
            apply(ins, $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                  6'($urandom_range(0, 63)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
